// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the round-robin counter scheduler.
// Optional feature macro: COUNTER_SCHED_PAUSE_EN (see counter_sched.sv).
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW_DEFAULT = 8;
  localparam int NREQ_MAX   = 8;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after pointer,
// wrapping around. Produces a one-hot grant and its index.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  int best_d_s;
  int best_i_s;
  int dist_s;

  // Find the requester with the smallest rotated distance from the pointer.
  always_comb begin
    best_d_s = NREQ;
    best_i_s = 0;
    dist_s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (i >= int'(pointer)) begin
        dist_s = i - int'(pointer);
      end else begin
        dist_s = i + NREQ - int'(pointer);
      end
      if (req[i] && (dist_s < best_d_s)) begin
        best_d_s = dist_s;
        best_i_s = i;
      end else begin
        best_d_s = best_d_s;
      end
    end
  end

  // Expand the winning index into a one-hot grant (all zero when nobody asks).
  always_comb begin
    gnt = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = (best_d_s < NREQ) && (best_i_s == i);
    end
    gnt_idx = IW'(best_i_s);
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one external up-counter between NREQ
// requesters. Sole driver of the counter's reset and enable.
// Optional macro COUNTER_SCHED_PAUSE_EN adds a 'pause' input that freezes
// the counter while a run is in progress.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic              done,
  output logic [CW-1:0]     result,
  output logic              cnt_reset,
  output logic              cnt_enable,
  input  logic [CW-1:0]     cnt_count
`ifdef COUNTER_SCHED_PAUSE_EN
  ,
  input  logic              pause
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_r;
  logic [NREQ-1:0]  grant_r;
  logic             done_r;
  logic [CW-1:0]    result_r;
  logic             cnt_reset_r;
  logic [CW-1:0]    len_q_r;
  logic [IW-1:0]    ptr_r;
  logic [IW-1:0]    own_idx_r;

  logic [NREQ-1:0]  pick_gnt_s;
  logic [IW-1:0]    pick_idx_s;
  logic [CW-1:0]    len_sel_s;
  logic             own_req_s;
  logic             pause_s;
  logic             cnt_enable_s;
  logic [IW-1:0]    ptr_next_s;

`ifdef COUNTER_SCHED_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .pointer (ptr_r),
    .gnt     (pick_gnt_s),
    .gnt_idx (pick_idx_s)
  );

  assign own_req_s  = |(req & grant_r);
  assign ptr_next_s = IW'(wrap_inc(int'(own_idx_r), NREQ));

  // Length slice belonging to the requester the arbiter would pick now.
  always_comb begin
    len_sel_s = {CW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt_s[i]) begin
        len_sel_s = len[i*CW +: CW];
      end else begin
        len_sel_s = len_sel_s;
      end
    end
  end

  // Counter enable is combinational so the counter stops exactly at len_q
  // and an abort (owner drops req) stops it in the same cycle.
  always_comb begin
    if ((state_r == RUN) && own_req_s && !pause_s && (cnt_count != len_q_r)) begin
      cnt_enable_s = 1'b1;
    end else begin
      cnt_enable_s = 1'b0;
    end
  end

  // Scheduler FSM with registered grant/done/result/counter-reset outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      grant_r     <= {NREQ{1'b0}};
      done_r      <= 1'b0;
      result_r    <= {CW{1'b0}};
      cnt_reset_r <= 1'b1;
      len_q_r     <= {CW{1'b0}};
      ptr_r       <= {IW{1'b0}};
      own_idx_r   <= {IW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (|req) begin
            state_r     <= CLEAR;
            grant_r     <= pick_gnt_s;
            own_idx_r   <= pick_idx_s;
            len_q_r     <= len_sel_s;
            cnt_reset_r <= 1'b1;
          end else begin
            cnt_reset_r <= 1'b0;
          end
        end
        CLEAR: begin
          cnt_reset_r <= 1'b0;
          if (!own_req_s) begin
            state_r <= IDLE;
            grant_r <= {NREQ{1'b0}};
            ptr_r   <= ptr_next_s;
          end else if (len_q_r == {CW{1'b0}}) begin
            // Zero-length run: counter is being cleared this cycle, so the
            // final count is known to be zero.
            state_r  <= DONE;
            done_r   <= 1'b1;
            result_r <= {CW{1'b0}};
          end else begin
            state_r <= RUN;
          end
        end
        RUN: begin
          cnt_reset_r <= 1'b0;
          if (!own_req_s) begin
            state_r <= IDLE;
            grant_r <= {NREQ{1'b0}};
            ptr_r   <= ptr_next_s;
          end else if (cnt_count == len_q_r) begin
            state_r  <= DONE;
            done_r   <= 1'b1;
            result_r <= cnt_count;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          done_r      <= 1'b0;
          grant_r     <= {NREQ{1'b0}};
          cnt_reset_r <= 1'b0;
          ptr_r       <= ptr_next_s;
        end
        default: begin
          state_r     <= IDLE;
          done_r      <= 1'b0;
          grant_r     <= {NREQ{1'b0}};
          cnt_reset_r <= 1'b0;
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign done       = done_r;
  assign result     = result_r;
  assign cnt_reset  = cnt_reset_r;
  assign cnt_enable = cnt_enable_s;

endmodule

// File: tb/tb_counter_sched.sv
// Directed self-checking bench for counter_sched with a behavioural model
// of the shared 8-bit up-counter. Define COUNTER_SCHED_PAUSE_EN to also
// exercise the pause input.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]   grant;
  logic              done;
  logic [CW-1:0]     result;
  logic              cnt_reset;
  logic              cnt_enable;
  logic [CW-1:0]     cnt_count;
`ifdef COUNTER_SCHED_PAUSE_EN
  logic              pause;
`endif

  int n_checks;
  int n_fail;

  counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .len        (len),
    .grant      (grant),
    .done       (done),
    .result     (result),
    .cnt_reset  (cnt_reset),
    .cnt_enable (cnt_enable),
    .cnt_count  (cnt_count)
`ifdef COUNTER_SCHED_PAUSE_EN
    ,
    .pause      (pause)
`endif
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared counter model: synchronous clear, count up while enabled
  always_ff @(posedge clk) begin
    if (cnt_reset) begin
      cnt_count <= 8'd0;
    end else if (cnt_enable) begin
      cnt_count <= cnt_count + 8'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = 0;
    while ((done !== 1'b1) && (cycles < bound)) begin
      tick();
      cycles++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  int cyc;
  logic [NREQ-1:0] exp_g;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    req   = 4'b0000;
    len   = 32'd0;
`ifdef COUNTER_SCHED_PAUSE_EN
    pause = 1'b0;
`endif

    // ---- reset state ----
    @(negedge clk);
    tick();
    tick();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_cnt_reset", {31'd0, cnt_reset}, 32'd1);
    chk("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_cnt_reset", {31'd0, cnt_reset}, 32'd0);

    // ---- 1: single requester, len=5 ----
    req = 4'b0001;
    len[0*CW +: CW] = 8'd5;
    tick();
    chk("t1_grant", {28'd0, grant}, 32'h1);
    chk("t1_clear", {31'd0, cnt_reset}, 32'd1);
    chk("t1_clear_en", {31'd0, cnt_enable}, 32'd0);
    tick();
    chk("t1_count0", {24'd0, cnt_count}, 32'd0);
    chk("t1_clear_1cyc", {31'd0, cnt_reset}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_count", {24'd0, cnt_count}, k);
    end
    chk("t1_en_stop", {31'd0, cnt_enable}, 32'd0);
    chk("t1_no_done_yet", {31'd0, done}, 32'd0);
    tick();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_result", {24'd0, result}, 32'd5);
    chk("t1_grant_in_done", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_grant_clr", {28'd0, grant}, 32'd0);
    chk("t1_hold", {24'd0, cnt_count}, 32'd5);
    chk("t1_en_after", {31'd0, cnt_enable}, 32'd0);

    // ---- 2: all request, round robin from pointer 0 ----
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = 8'd3;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % NREQ);
      tick();
      chk("t2_grant", {28'd0, grant}, {28'd0, exp_g});
      wait_done(20, cyc);
      chk("t2_latency", cyc, 32'd5);
      chk("t2_result", {24'd0, result}, 32'd3);
      chk("t2_grant_done", {28'd0, grant}, {28'd0, exp_g});
      if (i == 4) req = 4'b0000;
      tick();
      chk("t2_gap_grant", {28'd0, grant}, 32'd0);
      chk("t2_gap_done", {31'd0, done}, 32'd0);
    end

    // ---- 3: zero-length run on req[2] (pointer is 1) ----
    req = 4'b0100;
    len[2*CW +: CW] = 8'd0;
    tick();
    chk("t3_grant", {28'd0, grant}, 32'h4);
    chk("t3_en_clear", {31'd0, cnt_enable}, 32'd0);
    tick();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_result", {24'd0, result}, 32'd0);
    chk("t3_en_done", {31'd0, cnt_enable}, 32'd0);
    req = 4'b0000;
    tick();
    chk("t3_idle", {28'd0, grant}, 32'd0);

    // ---- 4: abort req[1] at count 7 (pointer is 3) ----
    req = 4'b0010;
    len[1*CW +: CW] = 8'd20;
    tick();
    chk("t4_grant", {28'd0, grant}, 32'h2);
    tick();
    for (int k = 0; k < 7; k++) tick();
    chk("t4_count7", {24'd0, cnt_count}, 32'd7);
    chk("t4_en_run", {31'd0, cnt_enable}, 32'd1);
    req = 4'b0000;
    #1;
    chk("t4_en_abort", {31'd0, cnt_enable}, 32'd0);
    @(negedge clk);
    tick();
    chk("t4_idle_grant", {28'd0, grant}, 32'd0);
    chk("t4_no_done", {31'd0, done}, 32'd0);
    chk("t4_count_held", {24'd0, cnt_count}, 32'd7);
    req = 4'b0110;
    tick();
    chk("t4_next_grant", {28'd0, grant}, 32'h4);
    chk("t4_count_still7", {24'd0, cnt_count}, 32'd7);
    req = 4'b0000;
    tick();
    chk("t4_abort_clear", {28'd0, grant}, 32'd0);
    chk("t4_abort_nodone", {31'd0, done}, 32'd0);

    // ---- 5: reset mid-run ----
    req = 4'b0001;
    len[0*CW +: CW] = 8'd50;
    tick();
    chk("t5_grant", {28'd0, grant}, 32'h1);
    tick();
    for (int k = 0; k < 10; k++) tick();
    chk("t5_count10", {24'd0, cnt_count}, 32'd10);
    reset = 1'b1;
    tick();
    chk("t5_rst_grant", {28'd0, grant}, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    chk("t5_rst_cnt_reset", {31'd0, cnt_reset}, 32'd1);
    chk("t5_rst_en", {31'd0, cnt_enable}, 32'd0);
    len[0*CW +: CW] = 8'd2;
    req = 4'b1011;
    reset = 1'b0;
    tick();
    chk("t5_ptr0_grant", {28'd0, grant}, 32'h1);
    wait_done(20, cyc);
    chk("t5_latency", cyc, 32'd4);
    chk("t5_result", {24'd0, result}, 32'd2);
    req = 4'b0000;
    tick();

    // ---- max length, no wrap (pointer is 1, only req[3]) ----
    req = 4'b1000;
    len[3*CW +: CW] = 8'd255;
    tick();
    chk("max_grant", {28'd0, grant}, 32'h8);
    wait_done(300, cyc);
    chk("max_latency", cyc, 32'd257);
    chk("max_result", {24'd0, result}, 32'd255);
    req = 4'b0000;
    tick();
    chk("max_no_wrap", {24'd0, cnt_count}, 32'd255);
    chk("max_en_off", {31'd0, cnt_enable}, 32'd0);

`ifdef COUNTER_SCHED_PAUSE_EN
    // ---- 6: pause for 4 cycles at count 4 (pointer is 0) ----
    req = 4'b0001;
    len[0*CW +: CW] = 8'd10;
    tick();
    chk("t6_grant", {28'd0, grant}, 32'h1);
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("t6_count4", {24'd0, cnt_count}, 32'd4);
    pause = 1'b1;
    #1;
    chk("t6_en_paused", {31'd0, cnt_enable}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_hold", {24'd0, cnt_count}, 32'd4);
    end
    pause = 1'b0;
    wait_done(20, cyc);
    chk("t6_latency", cyc, 32'd7);
    chk("t6_result", {24'd0, result}, 32'd10);
    req = 4'b0000;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
